thor2023_cache_tag_ctrl: RTL

Parametrised N-way set-associative cache tag store with per-way valid bits. Also performs hit/way lookup, round-robin victim selection and single-line or whole-cache invalidation. Intended for both the I$ and D$ front ends: the fetch or load unit issues lookups, and the miss/fill engine issues tag writes and invalidates. The whole-array clear runs as a sweep state machine, so the tag RAM carries no reset and can map to distributed RAM.

---
 rtl/thor2023_cache_tag_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/thor2023_cache_tag_ctrl.sv
// N-way set-associative cache tag store with per-way valid bits, hit/victim lookup,
// fills, single-line invalidate and a whole-array clear sweep.
module thor2023_cache_tag_ctrl #(
  parameter int AWID   = 32,
  parameter int LINES  = 256,
  parameter int WAYS   = 4,
  parameter int LOBIT  = 6,
  parameter int TAGBIT = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [AWID-1:0]          adr_i,
  output logic                     rdy_o,
  output logic                     vld_o,
  output logic                     hit_o,
  output logic [$clog2(WAYS)-1:0]  hit_way_o,
  output logic [$clog2(WAYS)-1:0]  victim_way_o,
  input  logic                     wr_i,
  input  logic [$clog2(WAYS)-1:0]  wr_way_i,
  input  logic [AWID-1:0]          wr_adr_i,
  input  logic                     inv_line_i,
  input  logic [AWID-1:0]          inv_adr_i,
  input  logic                     inv_all_i,
  output logic                     busy_o
);
  localparam int IW = $clog2(LINES);
  localparam int WW = $clog2(WAYS);
  localparam int TW = AWID - TAGBIT;
  localparam logic [IW-1:0] SC_LAST = IW'(LINES - 1);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] sc_q, sc_d;

  logic [TW-1:0]   tag_q   [LINES][WAYS];
  logic [WAYS-1:0] valid_q [LINES];
  logic [WW-1:0]   rr_q    [LINES];

  logic          vld_q, hit_q;
  logic [WW-1:0] hit_way_q, victim_q;

  logic [IW-1:0] lk_idx, wr_idx, inv_idx;
  logic [TW-1:0] lk_tag, wr_tag, inv_tag;

  assign lk_idx  = adr_i[LOBIT+IW-1:LOBIT];
  assign wr_idx  = wr_adr_i[LOBIT+IW-1:LOBIT];
  assign inv_idx = inv_adr_i[LOBIT+IW-1:LOBIT];
  assign lk_tag  = adr_i[AWID-1:TAGBIT];
  assign wr_tag  = wr_adr_i[AWID-1:TAGBIT];
  assign inv_tag = inv_adr_i[AWID-1:TAGBIT];

  // Line-offset bits never take part in tag or index selection.
  logic unused_offset;
  assign unused_offset = ^{adr_i[LOBIT-1:0], wr_adr_i[LOBIT-1:0], inv_adr_i[LOBIT-1:0]};

  logic idle, sweep_en, lookup_en, inv_en, fill_en;
  assign idle      = (state_q == ST_IDLE);
  assign sweep_en  = rst & ~idle;
  assign lookup_en = rst & idle & req_i & ~inv_all_i;
  assign inv_en    = rst & idle & inv_line_i & ~inv_all_i;
  assign fill_en   = rst & idle & wr_i & ~inv_line_i & ~inv_all_i;

  // Sweep sequencing: one set cleared per cycle, then back to normal operation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      ST_SWEEP: begin
        sc_d = sc_q + IW'(1);
        if (sc_q == SC_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (inv_all_i) begin
          state_d = ST_SWEEP;
          sc_d    = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  // Lookup: lowest-index valid tag match, lowest-index free way, else round-robin pointer.
  logic          lk_hit, lk_free;
  logic [WW-1:0] lk_hit_way, lk_free_way, lk_victim;
  logic [WAYS-1:0] inv_match;

  always_comb begin
    lk_hit      = 1'b0;
    lk_hit_way  = '0;
    lk_free     = 1'b0;
    lk_free_way = '0;
    inv_match   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WW'(w);
      end
      if (!valid_q[lk_idx][w]) begin
        lk_free     = 1'b1;
        lk_free_way = WW'(w);
      end
      inv_match[w] = (tag_q[inv_idx][w] == inv_tag);
    end
    lk_victim = lk_free ? lk_free_way : rr_q[lk_idx];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q   <= ST_SWEEP;
      sc_q      <= '0;
      vld_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      victim_q  <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      vld_q   <= lookup_en;
      if (lookup_en) begin
        hit_q     <= lk_hit;
        hit_way_q <= lk_hit_way;
        victim_q  <= lk_victim;
      end
    end
  end

  // NOTE: tag/valid/rr arrays carry no reset; the sweep clears valid and rr so they can map to RAM.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[wr_idx][wr_way_i] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      valid_q[sc_q] <= '0;
      rr_q[sc_q]    <= '0;
    end else if (inv_en) begin
      valid_q[inv_idx] <= valid_q[inv_idx] & ~inv_match;
    end else if (fill_en) begin
      valid_q[wr_idx][wr_way_i] <= 1'b1;
      rr_q[wr_idx]              <= wr_way_i + WW'(1);
    end
  end

  assign rdy_o        = idle;
  assign busy_o       = ~idle;
  assign vld_o        = vld_q;
  assign hit_o        = hit_q;
  assign hit_way_o    = hit_way_q;
  assign victim_way_o = victim_q;

endmodule
